// File: rtl/uart_rx_chunk_decoder.sv
// uart_rx_chunk_decoder: strips 0x00 escape framing from a UART RX byte stream and
// presents one typed chunk per 0x00 0x01 terminator. Optional inter-byte timeout: RX_CHUNK_TIMEOUT_EN.

module uart_rx_chunk_decoder #(
   parameter int BUFFER_BYTE_SIZE  = 5,
   parameter int BUFFER_INDEX_SIZE = 32,
   parameter int TIMEOUT_TICKS     = 1000000
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          rx_ready,
   input  logic [7:0]                    rx_data,
   output logic                          is_chunk_ready,
   output logic [7:0]                    chunk_type,
   output logic [BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
   output logic [BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
   output logic                          chunk_error,
   output logic [1:0]                    error_code
);

   localparam int              CNT_W    = $clog2(BUFFER_BYTE_SIZE + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_BYTE_SIZE);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_START_ESC = 2'd1;
   localparam logic [1:0] S_DATA      = 2'd2;
   localparam logic [1:0] S_DATA_ESC  = 2'd3;

   localparam logic [1:0] ERR_OVERFLOW = 2'd1;
   localparam logic [1:0] ERR_FRAMING  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   logic [1:0]                    state;
   logic [1:0]                    state_nxt;
   logic [7:0]                    work_type;
   logic [CNT_W-1:0]              work_cnt;
   logic [BUFFER_BYTE_SIZE*8-1:0] work_buf;

   logic       start_chunk;
   logic       store_en;
   logic [7:0] store_val;
   logic       complete;
   logic       err_fire;
   logic [1:0] err_nxt;
   logic       buf_full;
   logic       timer_hit;

   assign buf_full = (work_cnt == FULL_CNT);

`ifdef RX_CHUNK_TIMEOUT_EN
   localparam int               TMR_W    = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_TICKS - 1);

   logic [TMR_W-1:0] timer;

   // A byte arriving in the expiry cycle wins over the timeout.
   assign timer_hit = !rx_ready && (state != S_IDLE) && (timer == TMR_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         timer <= '0;
      end else if (rx_ready || (state == S_IDLE) || timer_hit) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end
`else
   // Never true for a legal tick count; partial chunks wait indefinitely.
   assign timer_hit = (TIMEOUT_TICKS < 0);
`endif

   // NOTE: every signal of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      start_chunk = 1'b0;
      store_en    = 1'b0;
      store_val   = rx_data;
      complete    = 1'b0;
      err_fire    = 1'b0;
      err_nxt     = ERR_OVERFLOW;

      if (rx_ready) begin
         case (state)
            S_IDLE: begin
               if (rx_data == 8'h00) state_nxt = S_START_ESC;
            end
            S_START_ESC: begin
               if (rx_data >= 8'h02) begin
                  start_chunk = 1'b1;
                  state_nxt   = S_DATA;
               end else if (rx_data == 8'h01) begin
                  state_nxt = S_IDLE;
               end
            end
            S_DATA: begin
               if (rx_data == 8'h00) begin
                  state_nxt = S_DATA_ESC;
               end else if (buf_full) begin
                  err_fire  = 1'b1;
                  err_nxt   = ERR_OVERFLOW;
                  state_nxt = S_IDLE;
               end else begin
                  store_en = 1'b1;
               end
            end
            default: begin
               if (rx_data == 8'h00) begin
                  if (buf_full) begin
                     err_fire  = 1'b1;
                     err_nxt   = ERR_OVERFLOW;
                     state_nxt = S_IDLE;
                  end else begin
                     store_en  = 1'b1;
                     store_val = 8'h00;
                     state_nxt = S_DATA;
                  end
               end else if (rx_data == 8'h01) begin
                  complete  = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  // Unescaped start marker inside a chunk: abandon it and open the new one.
                  err_fire    = 1'b1;
                  err_nxt     = ERR_FRAMING;
                  start_chunk = 1'b1;
                  state_nxt   = S_DATA;
               end
            end
         endcase
      end else if (timer_hit) begin
         err_fire  = 1'b1;
         err_nxt   = ERR_TIMEOUT;
         state_nxt = S_IDLE;
      end
   end

   // NOTE: sequential state uses <= so every register updates together at the edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: the working buffer is reset, unlike a RAM, because its zeroed tail is visible on chunk_bytes.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         work_type <= 8'h00;
         work_cnt  <= '0;
         work_buf  <= '0;
      end else if (start_chunk) begin
         work_type <= rx_data;
         work_cnt  <= '0;
         work_buf  <= '0;
      end else if (store_en) begin
         for (int i = 0; i < BUFFER_BYTE_SIZE; i++) begin
            if (work_cnt == CNT_W'(i)) work_buf[8*i +: 8] <= store_val;
         end
         work_cnt <= work_cnt + 1'b1;
      end
   end

   // Output copy of the working registers, so reception of the next chunk can proceed.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         is_chunk_ready  <= 1'b0;
         chunk_type      <= 8'h00;
         chunk_byte_size <= '0;
         chunk_bytes     <= '0;
         chunk_error     <= 1'b0;
         error_code      <= 2'd0;
      end else begin
         is_chunk_ready <= complete;
         chunk_error    <= err_fire;
         if (complete) begin
            chunk_type      <= work_type;
            chunk_byte_size <= BUFFER_INDEX_SIZE'(work_cnt);
            chunk_bytes     <= work_buf;
         end
         if (err_fire) error_code <= err_nxt;
      end
   end

endmodule
